// File: rtl/cache_replacement_unit.sv
// Per-set victim-way selector (FIFO / tree-PLRU / LFSR-random); invalid ways win; state cleared by post-reset sweep.
// Optional eviction counter when REPL_STATS_EN is defined.
module cache_replacement_unit #(
  parameter int WAY_COUNT = 4,
  parameter int SET_COUNT = 64,
  parameter int POLICY    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(SET_COUNT)-1:0] set,
  input  logic [WAY_COUNT-1:0]         valid_ways,
  output logic [$clog2(WAY_COUNT)-1:0] way,
  input  logic                         taken,
  input  logic                         hit,
  input  logic [$clog2(SET_COUNT)-1:0] hit_set,
  input  logic [$clog2(WAY_COUNT)-1:0] hit_way,
  output logic                         ready
`ifdef REPL_STATS_EN
  ,
  output logic [31:0]                  evict_cnt
`endif
);
  localparam int SB = $clog2(SET_COUNT);
  localparam int WB = $clog2(WAY_COUNT);
  localparam int TW = WAY_COUNT - 1;
  localparam int SW = (POLICY == 1) ? TW : WB;

  if (POLICY < 0 || POLICY > 2) begin : g_bad_policy
    $error("cache_replacement_unit: POLICY must be 0, 1 or 2");
  end

  typedef enum logic {INIT, IDLE} fsm_t;

  fsm_t          fsm;
  logic [SB-1:0] ptr;
  logic [SW-1:0] state_mem [SET_COUNT];
  logic [SW-1:0] cur, taken_next, hit_next;
  logic [WB-1:0] inv_way, pol_way;
  logic          any_invalid, do_taken, do_hit;

  // Tree node k sits at level l with offset o = k - (2^l - 1) from the left of that level.
  function automatic logic [WB-1:0] plru_walk(input logic [TW-1:0] t);
    logic [WB-1:0] p;
    logic          b;
    p = '0;
    for (int l = 0; l < WB; l++) begin
      b = 1'b0;
      for (int o = 0; o < (1 << l); o++)
        if (int'(p) == o) b = t[(1 << l) - 1 + o];
      p = (p << 1) | WB'(b);
    end
    return p;
  endfunction

  function automatic logic [TW-1:0] plru_touch(input logic [TW-1:0] t, input logic [WB-1:0] w);
    logic [TW-1:0] r;
    r = t;
    for (int l = 0; l < WB; l++)
      for (int o = 0; o < (1 << l); o++)
        if ((int'(w) >> (WB - l)) == o) r[(1 << l) - 1 + o] = ~w[WB - 1 - l];
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm   <= INIT;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      case (fsm)
        INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == SB'(SET_COUNT - 1)) begin
            fsm   <= IDLE;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  assign cur      = state_mem[set];
  assign do_taken = taken & ready;
  assign do_hit   = hit & ready & (POLICY == 1) & ~(do_taken & (hit_set == set));

  always_comb begin
    inv_way     = '0;
    any_invalid = 1'b0;
    for (int i = WAY_COUNT - 1; i >= 0; i--) begin
      if (!valid_ways[i]) begin
        inv_way     = WB'(i);
        any_invalid = 1'b1;
      end
    end
  end

  if (POLICY == 0) begin : g_fifo
    assign pol_way    = cur;
    assign taken_next = (&valid_ways) ? cur + 1'b1 : cur;
    assign hit_next   = cur;
  end else if (POLICY == 1) begin : g_plru
    assign pol_way    = plru_walk(cur);
    assign taken_next = plru_touch(cur, way);
    assign hit_next   = plru_touch(state_mem[hit_set], hit_way);
  end else begin : g_rand
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)         lfsr <= 16'hACE1;
      else if (do_taken) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
    assign pol_way    = lfsr[WB-1:0];
    assign taken_next = cur;
    assign hit_next   = cur;
  end

  assign way = !ready ? '0 : (any_invalid ? inv_way : pol_way);

  // No reset on the array so it can map onto a plain RAM; the sweep clears it.
  always_ff @(posedge clk) begin
    if (!ready) begin
      state_mem[ptr] <= '0;
    end else begin
      if (do_taken) state_mem[set]     <= taken_next;
      if (do_hit)   state_mem[hit_set] <= hit_next;
    end
  end

`ifdef REPL_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      evict_cnt <= '0;
    else if (do_taken && (&valid_ways) && evict_cnt != 32'hFFFF_FFFF)
      evict_cnt <= evict_cnt + 32'd1;
  end
`endif

endmodule
